// File: rtl/bool_pkg.sv
// bool_pkg: shared mode encodings, FSM state type and legal range of N for bool_sweep.
// Rev 1.0
`default_nettype none

package bool_pkg;

   localparam int N_MIN = 2;
   localparam int N_MAX = 6;

   localparam logic [1:0] MODE_NAND_Z = 2'd0;
   localparam logic [1:0] MODE_AND    = 2'd1;
   localparam logic [1:0] MODE_OR     = 2'd2;
   localparam logic [1:0] MODE_XOR    = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bool_func.sv
// bool_func: combinational evaluation of the selected Boolean function over an N-bit vector.
// Rev 1.0
`default_nettype none

module bool_func
   import bool_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [1:0]   mode,
   input  logic [N-1:0] vec,
   output logic         s
);

   always_comb begin
      s = 1'b0;
      case (mode)
         // z gated by the NAND of every higher-order operand
         MODE_NAND_Z: s = vec[0] & ~(&vec[N-1:1]);
         MODE_AND:    s = &vec;
         MODE_OR:     s = |vec;
         MODE_XOR:    s = ^vec;
         default:     s = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/bool_sweep.sv
// bool_sweep: walks every N-bit input vector once, building the truth table and a count of true rows.
// Rev 1.0
`default_nettype none

module bool_sweep
   import bool_pkg::*;
#(
   parameter int N = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic [N-1:0]      vec,
   output logic              s,
   output logic              valid,
   output logic              busy,
   output logic              done,
   output logic [N:0]        ones,
   output logic [(1<<N)-1:0] mask
);

   localparam logic [N-1:0] VEC_ONE = {{(N-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     state_next;
   logic [1:0] mode_latched;
   logic       last_row;

   assign last_row = &vec;

   bool_func #(.N(N)) u_func (
      .mode (mode_latched),
      .vec  (vec),
      .s    (s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_row) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec          <= '0;
         ones         <= '0;
         mask         <= '0;
         mode_latched <= MODE_NAND_Z;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec          <= '0;
                  ones         <= '0;
                  mask         <= '0;
                  mode_latched <= mode;
               end
            end
            RUN: begin
               mask[vec] <= s;
               ones      <= ones + {{N{1'b0}}, s};
               // vec parks on the final row so the result stays readable afterwards
               if (!last_row) begin
                  vec <= vec + VEC_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid = (state == RUN);
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

endmodule

`default_nettype wire
